ssd_scan_ctrl: RTL and testbench
================================

Name: ssd_scan_ctrl

Overview:
Scan controller for the multiplexed PMOD seven-segment display. Owns the per-digit dwell/blank schedule, the digit-select output, brightness PWM and optional leading-zero blanking. Accepts new display values over a valid/ready handshake and swaps them in only on frame boundaries, so the display never tears. Sits between the top-level counter/value producers and the PMOD pins; replaces the ad-hoc counter-bit digit select.

Parameters:
NUM_DIGITS, 2, number of multiplexed digits (≥2); digit 0 = least-significant nibble.
DWELL_CYCLES, 4096, cycles per digit SHOW phase; power of two, ≥16.
BLANK_CYCLES, 64, all-segments-off dead time before each SHOW (≥1), anti-ghosting.

Ports:
clk  in  1  system clock (PLL output).
rst_n  in  1  asynchronous active-low reset.
enable  in  1  scan enable; 0 forces display dark.
value_in  in  4*NUM_DIGITS  hex nibbles to display.
value_valid  in  1  value_in offered.
value_ready  out  1  controller can accept a value.
brightness  in  4  0 = dimmest (1/16 duty), 15 = full.
lzb_en  in  1  leading-zero blanking enable.
seg_n  out  7  active-low segments, bit0=a … bit6=g.
dig_idx  out  $clog2(NUM_DIGITS)  index of the digit being driven.
frame_done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (async, rst_n=0): state IDLE, seg_n=7'h7F, dig_idx=0, frame_done=0, display reg=0, pending empty, value_ready=1, counters 0.
- value_ready = !pending_full. Accept on value_valid&&value_ready at the clock edge; pending_full set. value_in must be held while valid && !ready.
- States: IDLE, BLANK, SHOW.
- IDLE (enable=0): seg_n=7F, dig_idx=0; a full pending value moves to the display reg the cycle after capture. enable=1 -> BLANK, digit 0, cnt=0.
- BLANK: seg_n=7F for BLANK_CYCLES cycles; dig_idx already at the new digit, so the select settles while dark. Then -> SHOW with cnt=0, brightness sampled.
- SHOW: lasts DWELL_CYCLES. Segments lit while cnt < (brightness_s+1)*(DWELL_CYCLES/16), else seg_n=7F.
- Lit pattern = hex_to_ssd(display nibble[dig_idx]). Glyphs a-g, active-low: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
- Leading-zero blanking: with lzb_en=1, digit k>0 is dark when it and every higher nibble are zero. Digit 0 is never blanked.
- End of SHOW: if dig_idx<NUM_DIGITS-1, go to BLANK with dig_idx+1.
- End of SHOW on the last digit: frame_done=1 for that last cycle; dig_idx wraps to 0 and the FSM goes to BLANK. On the same edge a full pending value moves into the display reg and pending clears. value_ready rises the following cycle, so there is no same-cycle accept.
- Frame length = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- enable drops in any state: next edge goes to IDLE, seg_n=7F, dig_idx=0, counters cleared, no frame_done.
- Outputs seg_n, dig_idx and frame_done are registered: they reflect state/cnt one cycle after the edge that updates them.
- Brightness or lzb_en changes mid-SHOW take effect at the next SHOW; lzb_en is evaluated combinationally on the display reg.

Decomposition:
- Package ssd_pkg: the hex_to_ssd function (glyph table above), SEG_OFF=7'h7F, and the scan_state_t enum {IDLE,BLANK,SHOW}.
- One sub-module, ssd_value_buffer: the pending/display double buffer, valid/ready logic and frame-boundary swap.
- ssd_scan_ctrl keeps the FSM, counters, PWM compare and LZB logic.

Test Plan:
Bench configuration: NUM_DIGITS=2, DWELL_CYCLES=16, BLANK_CYCLES=4.
1. Reset: rst_n=0 mid-run -> immediately seg_n=7F, dig_idx=0, value_ready=1, frame_done=0.
2. Load 0x3A, brightness=15, enable=1 -> per frame: 4 cycles 7F, 16 cycles 0001000 on idx0, 4 cycles 7F, 16 cycles 0110000 on idx1. frame_done pulses every 40 cycles.
3. Backpressure: accept 0x12 then hold valid with 0x34 -> ready=0 until the cycle after frame_done, 0x34 accepted then. Next frame shows 12, the frame after shows 34.
4. brightness=3 -> in each 16-cycle SHOW, lit 4 cycles then 7F for 12 cycles.
5. lzb_en=1: value 0x05 -> idx1 stays 7F all frame, idx0 shows 0010010. Value 0x00 -> idx0 shows 1000000.
6. enable=0 at SHOW cycle 7 of idx1 -> next cycle seg_n=7F, dig_idx=0, no frame_done. Re-enable -> restarts with BLANK on idx0.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared types and glyph decoding for the seven-segment scan controller.
package ssd_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;

  // Active-low glyphs, bit6=g ... bit0=a
  function automatic logic [6:0] hex_to_ssd(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_value_buffer.sv
// Pending/display double buffer; a new value only reaches the display on a swap,
// so a frame is never drawn from two different values.
module ssd_value_buffer #(
  parameter int NUM_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic                    swap,
  output logic [4*NUM_DIGITS-1:0] display
);

  logic [4*NUM_DIGITS-1:0] pending;
  logic                    pending_full;

  assign value_ready = !pending_full;

  // Accept and swap are exclusive: accept needs an empty slot, swap a full one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      pending_full <= 1'b0;
      display      <= '0;
    end else if (value_valid && !pending_full) begin
      pending      <= value_in;
      pending_full <= 1'b1;
    end else if (swap && pending_full) begin
      display      <= pending;
      pending_full <= 1'b0;
    end
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan: per-digit blank/dwell schedule, PWM brightness,
// leading-zero blanking and tear-free value updates at frame boundaries.
//
//   state | meaning
//   IDLE  | scan disabled, display dark, digit 0 selected
//   BLANK | segments off while the digit select settles on the new digit
//   SHOW  | current digit driven, lit for the PWM share of the dwell
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int DWELL_CYCLES = 4096,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       value_in,
  input  logic                          value_valid,
  output logic                          value_ready,
  input  logic [3:0]                    brightness,
  input  logic                          lzb_en,
  output logic [6:0]                    seg_n,
  output logic [$clog2(NUM_DIGITS)-1:0] dig_idx,
  output logic                          frame_done
);

  localparam int DW    = $clog2(NUM_DIGITS);
  localparam int TMAX  = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW    = $clog2(TMAX);
  localparam int TW    = CW + 1;
  localparam int SLICE = DWELL_CYCLES / 16;
  localparam logic [DW-1:0] LAST = DW'(NUM_DIGITS - 1);

  scan_state_t             state;
  logic [DW-1:0]           dig;
  logic [CW-1:0]           tmr;
  logic [3:0]              bright_s;
  logic [4*NUM_DIGITS-1:0] display;
  logic [NUM_DIGITS-1:0]   hi_zero;
  logic [3:0]              nib;
  logic [TW-1:0]           elapsed;
  logic [TW-1:0]           lit_len;
  logic                    lit;
  logic                    lzb_dark;
  logic                    frame_end;
  logic                    swap;

  assign frame_end = enable && (state == SHOW) && (tmr == '0) && (dig == LAST);
  assign swap      = (state == IDLE) || frame_end;

  ssd_value_buffer #(.NUM_DIGITS(NUM_DIGITS)) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .swap        (swap),
    .display     (display)
  );

  // hi_zero[k]: nibble k and every nibble above it are zero
  always_comb begin
    hi_zero = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      hi_zero[k] = ((display >> (4 * k)) == '0);
    end
  end

  // The dwell timer counts down, so elapsed SHOW time is recovered for the PWM compare.
  always_comb begin
    nib      = display[{dig, 2'b00} +: 4];
    lzb_dark = lzb_en && (dig != '0) && hi_zero[dig];
    elapsed  = TW'(DWELL_CYCLES - 1) - {1'b0, tmr};
    lit_len  = TW'(bright_s) * TW'(SLICE) + TW'(SLICE);
    lit      = (elapsed < lit_len) && !lzb_dark;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dig        <= '0;
      tmr        <= '0;
      bright_s   <= '0;
      seg_n      <= SEG_OFF;
      dig_idx    <= '0;
      frame_done <= 1'b0;
    end else if (!enable) begin
      state      <= IDLE;
      dig        <= '0;
      tmr        <= '0;
      seg_n      <= SEG_OFF;
      dig_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      seg_n      <= SEG_OFF;
      dig_idx    <= dig;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          state <= BLANK;
          dig   <= '0;
          tmr   <= CW'(BLANK_CYCLES - 1);
        end
        BLANK: begin
          if (tmr == '0) begin
            state    <= SHOW;
            tmr      <= CW'(DWELL_CYCLES - 1);
            bright_s <= brightness;
          end else begin
            tmr <= tmr - CW'(1);
          end
        end
        SHOW: begin
          if (lit) seg_n <= hex_to_ssd(nib);
          if (tmr == '0) begin
            state      <= BLANK;
            tmr        <= CW'(BLANK_CYCLES - 1);
            dig        <= (dig == LAST) ? '0 : dig + DW'(1);
            frame_done <= (dig == LAST);
          end else begin
            tmr <= tmr - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          dig   <= '0;
          tmr   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl: whole expected frames are queued per step and
// popped one entry per clock against {frame_done, dig_idx, seg_n, value_ready}.
module tb_ssd_scan_ctrl;

  localparam int ND = 2;
  localparam int DW = 16;
  localparam int BL = 4;
  localparam logic [6:0] OFF = 7'h7F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] value_in = '0;
  logic       value_valid = 1'b0;
  logic       value_ready;
  logic [3:0] brightness = 4'd15;
  logic       lzb_en = 1'b0;
  logic [6:0] seg_n;
  logic [0:0] dig_idx;
  logic       frame_done;

  typedef struct packed {
    logic       fd;
    logic       idx;
    logic [6:0] seg;
    logic       rdy;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] send_q[$];
  logic       acc_prev = 1'b0;
  logic [6:0] glyph[16];
  int         n_cmp = 0;
  int         n_bad = 0;

  ssd_scan_ctrl #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .brightness  (brightness),
    .lzb_en      (lzb_en),
    .seg_n       (seg_n),
    .dig_idx     (dig_idx),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_hs();
    value_valid = (send_q.size() > 0);
    value_in    = value_valid ? send_q[0] : 8'h00;
    acc_prev    = value_valid && value_ready;
  endtask

  // Called once per negedge: ready only moves on posedges, so the value sampled
  // at the previous negedge tells whether the intervening edge accepted.
  task automatic hs_update();
    if (acc_prev) void'(send_q.pop_front());
    drive_hs();
  endtask

  task automatic push_frame(input logic [7:0] v, input int br, input logic lzb,
                            input logic rdy_body, input logic rdy_last);
    exp_t e;
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < BL; c++) begin
        e.fd  = 1'b0;
        e.idx = d[0];
        e.seg = OFF;
        e.rdy = rdy_body;
        exp_q.push_back(e);
      end
      for (int c = 0; c < DW; c++) begin
        logic       dark;
        logic       last;
        logic [3:0] nib;
        nib   = v[4*d +: 4];
        dark  = lzb && (d > 0) && ((v >> (4 * d)) == 8'h00);
        last  = (d == ND - 1) && (c == DW - 1);
        e.fd  = last;
        e.idx = d[0];
        e.seg = ((c < (br + 1) * (DW / 16)) && !dark) ? glyph[nib] : OFF;
        e.rdy = last ? rdy_last : rdy_body;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run(input int n, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hs_update();
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s[%0d] scoreboard empty observed=%h expected=entry", tag, i,
                 {frame_done, dig_idx, seg_n, value_ready});
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s[%0d] {fd,idx,seg,rdy}", tag, i),
              32'({frame_done, dig_idx, seg_n, value_ready}), 32'(e));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset {fd,idx,seg,rdy}", 32'({frame_done, dig_idx, seg_n, value_ready}),
          32'({1'b0, 1'b0, OFF, 1'b1}));
    rst_n = 1'b1;

    // Load 0x3A while idle: captured, then moved to display on the next edge
    send_q.push_back(8'h3A);
    drive_hs();
    @(negedge clk);
    hs_update();
    check("idle_load_busy", 32'(value_ready), 32'd0);
    @(negedge clk);
    hs_update();
    check("idle_load_free", 32'(value_ready), 32'd1);

    enable = 1'b1;
    @(negedge clk);
    hs_update();
    push_frame(8'h3A, 15, 1'b0, 1'b1, 1'b1);
    push_frame(8'h3A, 15, 1'b0, 1'b1, 1'b1);
    run(80, "f3a");

    // Backpressure: 0x12 accepted at once, 0x34 held until the frame swap
    send_q.push_back(8'h12);
    send_q.push_back(8'h34);
    drive_hs();
    push_frame(8'h3A, 15, 1'b0, 1'b0, 1'b1);
    push_frame(8'h12, 15, 1'b0, 1'b0, 1'b1);
    push_frame(8'h34, 15, 1'b0, 1'b1, 1'b1);
    run(120, "bp");

    brightness = 4'd3;
    push_frame(8'h34, 3, 1'b0, 1'b1, 1'b1);
    run(40, "pwm3");

    brightness = 4'd15;
    lzb_en = 1'b1;
    send_q.push_back(8'h05);
    drive_hs();
    push_frame(8'h34, 15, 1'b1, 1'b0, 1'b1);
    run(40, "lzb34");
    send_q.push_back(8'h00);
    drive_hs();
    push_frame(8'h05, 15, 1'b1, 1'b0, 1'b1);
    push_frame(8'h00, 15, 1'b1, 1'b1, 1'b1);
    run(80, "lzb05_00");

    // Drop enable with idx1 internally at SHOW cycle 7
    lzb_en = 1'b0;
    push_frame(8'h00, 15, 1'b0, 1'b1, 1'b1);
    run(31, "pre_dis");
    exp_q.delete();
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hs_update();
      check($sformatf("dis[%0d] {fd,idx,seg}", i), 32'({frame_done, dig_idx, seg_n}),
            32'({1'b0, 1'b0, OFF}));
    end

    enable = 1'b1;
    @(negedge clk);
    hs_update();
    push_frame(8'h00, 15, 1'b0, 1'b1, 1'b1);
    run(40, "reen");

    // Asynchronous reset mid-SHOW with a value pending
    send_q.push_back(8'h77);
    drive_hs();
    push_frame(8'h00, 15, 1'b0, 1'b0, 1'b1);
    run(10, "pre_rst");
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset {fd,idx,seg,rdy}", 32'({frame_done, dig_idx, seg_n, value_ready}),
          32'({1'b0, 1'b0, OFF, 1'b1}));
    send_q.delete();
    value_valid = 1'b0;
    acc_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    hs_update();
    push_frame(8'h00, 15, 1'b0, 1'b1, 1'b1);
    run(40, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
